// File: rtl/compare_sequencer_if.sv
// Configuration, run-control and counter-compare signals of compare_sequencer.
// The master side programs the table and starts runs; the slave side is the sequencer.
interface compare_sequencer_if #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int OUTW  = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_dur;
    logic [OUTW-1:0]  cfg_out;
    logic [7:0]       loops;
    logic             start;
    logic             stop;
    logic             cmp_match;
    logic [WIDTH-1:0] cmp_value;
    logic [AW-1:0]    phase;
    logic [OUTW-1:0]  phase_out;
    logic             busy;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_dur, cfg_out, loops, start, stop, cmp_match,
        input  cmp_value, phase, phase_out, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_dur, cfg_out, loops, start, stop, cmp_match,
        output cmp_value, phase, phase_out, busy, done
    );
endinterface

// File: rtl/compare_sequencer.sv
// Phase-table sequencer that steps a counter_compare timebase through programmed
// durations and output patterns, once, N times, or forever.
module compare_sequencer #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int OUTW  = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic              clk,
    input logic              rst,
    compare_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cmp_value_r, cmp_n;
    logic [AW-1:0]    phase_r, phase_n;
    logic [OUTW-1:0]  phase_out_r, out_n;
    logic [7:0]       loop_cnt, loop_n;
    logic             done_r, done_n;

    logic [WIDTH-1:0] dur_tab [DEPTH];
    logic [OUTW-1:0]  out_tab [DEPTH];

    logic [AW-1:0]    nxt_idx;
    logic             pass_end;

    // Index wraps naturally at DEPTH because DEPTH is a power of two.
    assign nxt_idx  = phase_r + AW'(1);
    assign pass_end = (nxt_idx == '0) || (dur_tab[nxt_idx] == '0);

    always_ff @(posedge clk) begin
        if (bus.cfg_we && state == IDLE) begin
            dur_tab[bus.cfg_addr] <= bus.cfg_dur;
            out_tab[bus.cfg_addr] <= bus.cfg_out;
        end
    end

    always_comb begin
        state_n  = state;
        cmp_n    = cmp_value_r;
        phase_n  = phase_r;
        out_n    = phase_out_r;
        loop_n   = loop_cnt;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (dur_tab[0] == '0) begin
                        done_n = 1'b1;
                    end else begin
                        phase_n = '0;
                        cmp_n   = dur_tab[0];
                        out_n   = out_tab[0];
                        loop_n  = bus.loops;
                        state_n = SETTLE;
                    end
                end
            end
            // A match seen here may be stale from before the compare change.
            SETTLE: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    cmp_n   = '0;
                    phase_n = '0;
                    out_n   = '0;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    cmp_n   = '0;
                    phase_n = '0;
                    out_n   = '0;
                end else if (bus.cmp_match) begin
                    if (pass_end) begin
                        if (loop_cnt == 8'd1) begin
                            state_n = IDLE;
                            cmp_n   = '0;
                            phase_n = '0;
                            out_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            // loop_cnt of zero means run forever, so it is never decremented.
                            if (loop_cnt > 8'd1) loop_n = loop_cnt - 8'd1;
                            phase_n = '0;
                            cmp_n   = dur_tab[0];
                            out_n   = out_tab[0];
                            state_n = SETTLE;
                        end
                    end else begin
                        phase_n = nxt_idx;
                        cmp_n   = dur_tab[nxt_idx];
                        out_n   = out_tab[nxt_idx];
                        state_n = SETTLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cmp_n   = '0;
                phase_n = '0;
                out_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmp_value_r <= '0;
            phase_r     <= '0;
            phase_out_r <= '0;
            loop_cnt    <= '0;
            done_r      <= 1'b0;
        end else begin
            state       <= state_n;
            cmp_value_r <= cmp_n;
            phase_r     <= phase_n;
            phase_out_r <= out_n;
            loop_cnt    <= loop_n;
            done_r      <= done_n;
        end
    end

    assign bus.cmp_value = cmp_value_r;
    assign bus.phase     = phase_r;
    assign bus.phase_out = phase_out_r;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;

endmodule

// File: tb/tb_compare_sequencer.sv
// Scoreboard bench for compare_sequencer: expected phase loads are queued when a run
// is started and popped whenever the observed {busy, phase, cmp_value, phase_out} changes.
module tb_compare_sequencer;
    localparam int WIDTH = 20;
    localparam int DEPTH = 8;
    localparam int OUTW  = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    compare_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUTW(OUTW)) bus ();

    compare_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUTW(OUTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] tup;
        int          dur;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_dur [DEPTH];
    logic [OUTW-1:0]  m_out [DEPTH];

    logic [63:0] prev_tup = '0;
    logic [63:0] cur_tup;
    exp_t        popped;
    int since = 0, last_dur = 0, ctr = 0, mode = 1, done_cnt = 0, done_base = 0;
    logic auto_match = 1'b0;
    logic man_match  = 1'b0;

    assign bus.cmp_match = auto_match | man_match;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tup_of(input logic b, input logic [AW-1:0] p,
                                           input logic [WIDTH-1:0] c, input logic [OUTW-1:0] o);
        return {36'd0, b, p, c, o};
    endfunction

    function automatic void push_load(input int idx, input int d);
        sbq.push_back('{tup_of(1'b1, AW'(idx), m_dur[idx], m_out[idx]), d});
    endfunction

    function automatic void push_end();
        sbq.push_back('{64'd0, 0});
    endfunction

    function automatic void push_passes(input int passes, input int d);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_dur[i] == '0) break;
                push_load(i, d);
            end
        end
    endfunction

    // Monitor and cmp_match generator: mode 0 off, 1 pulse 4 cycles after a load, 2 held high.
    always @(negedge clk) begin
        cur_tup = tup_of(bus.busy, bus.phase, bus.cmp_value, bus.phase_out);
        since++;
        if (bus.done) begin
            done_cnt++;
            check("done_with_busy", bus.busy, 1'b0);
        end
        if (cur_tup !== prev_tup) begin
            if (last_dur != 0) check("residency", since, last_dur);
            if (sbq.size() == 0) begin
                check("unexpected_change", cur_tup, prev_tup);
                last_dur = 0;
            end else begin
                popped = sbq.pop_front();
                check("phase_load", cur_tup, popped.tup);
                last_dur = popped.dur;
            end
            since      = 0;
            prev_tup   = cur_tup;
            ctr        = bus.busy ? 3 : 0;
            auto_match = 1'b0;
        end else if (ctr > 0) begin
            ctr--;
            auto_match = (ctr == 0);
        end else begin
            auto_match = 1'b0;
        end
        if (mode == 0) auto_match = 1'b0;
        else if (mode == 2) auto_match = 1'b1;
    end

    task automatic cfg_write(input int a, input int d, input int o, input bit model);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_dur  = WIDTH'(d);
        bus.cfg_out  = OUTW'(o);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (model) begin
            m_dur[a] = WIDTH'(d);
            m_out[a] = OUTW'(o);
        end
    endtask

    task automatic go(input int lp);
        bus.loops = 8'(lp);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", bus.busy, 1'b0);
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (bus.phase != AW'(p) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("phase_reached", bus.phase, p);
    endtask

    task automatic finish_run(input int exp_done);
        wait_idle(2000);
        check("done_edge", bus.done, exp_done);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt - done_base, exp_done);
        check("sb_drained", sbq.size(), 0);
        done_base = done_cnt;
    endtask

    task automatic write_base();
        cfg_write(0, 5, 1, 1'b1);
        cfg_write(1, 7, 2, 1'b1);
        cfg_write(2, 3, 4, 1'b1);
        cfg_write(3, 0, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_dur = '0; bus.cfg_out = '0;
        bus.loops = '0; bus.start = 1'b0; bus.stop = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmp_value", bus.cmp_value, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_phase_out", bus.phase_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pass, cmp_match 4 cycles after each load
        write_base();
        push_passes(1, 4); push_end();
        go(1);
        finish_run(1);
        check("idle_cmp_value", bus.cmp_value, 0);

        // Three passes: 9 loads, one done
        push_passes(3, 4); push_end();
        go(3);
        finish_run(1);

        // Infinite: 21 passes without done, then stop
        push_passes(21, 4);
        sbq[sbq.size()-1].dur = 0;
        go(0);
        begin
            int n = 0;
            while (sbq.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("infinite_progress", sbq.size(), 0);
        push_end();
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        finish_run(0);

        // cmp_match held high: every phase lasts exactly 2 cycles
        mode = 2;
        @(negedge clk);
        push_passes(1, 2); push_end();
        go(1);
        finish_run(1);
        mode = 1;
        @(negedge clk);

        // Full table, loops=2: wrap 7 -> 0 once
        for (int i = 0; i < DEPTH; i++) cfg_write(i, 10 + i, i + 1, 1'b1);
        push_passes(2, 4); push_end();
        go(2);
        finish_run(1);

        // stop together with cmp_match in phase 1
        write_base();
        push_load(0, 4); push_load(1, 0); push_end();
        go(1);
        wait_phase(1, 100);
        @(negedge clk);
        bus.stop = 1'b1; man_match = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; man_match = 1'b0;
        finish_run(0);
        check("stop_cmp_value", bus.cmp_value, 0);
        check("stop_phase_out", bus.phase_out, 0);

        // Empty program
        cfg_write(0, 0, 0, 1'b1);
        go(1);
        finish_run(1);

        // Table write during a run is ignored
        cfg_write(0, 5, 1, 1'b1);
        push_passes(1, 4); push_end();
        go(1);
        wait_phase(1, 100);
        cfg_write(2, 99, 15, 1'b0);
        finish_run(1);

        // Reset mid-run, then rerun the preserved table
        push_load(0, 4); push_load(1, 0); push_end();
        go(1);
        wait_phase(1, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cmp_value", bus.cmp_value, 0);
        check("mid_rst_phase", bus.phase, 0);
        check("mid_rst_phase_out", bus.phase_out, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        finish_run(0);
        push_passes(1, 4); push_end();
        go(1);
        finish_run(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
